// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl
// Multiplexed N-digit seven-segment scanner with a double-buffered load
// handshake. New content is staged in a pending buffer and only becomes
// visible at the scan wrap, so a frame never shows a half-updated display.
// Also provides per-digit decimal point, blank and blink masks,
// leading-zero suppression, 16-level brightness PWM and a ghost-blanking
// cycle after every digit switch.
module sseg_scan_ctrl #(
    parameter int N_DIGITS     = 4,
    parameter int PRESCALE     = 13,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  ld,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   blank,
    input  logic [N_DIGITS-1:0]   blink,
    input  logic                  lz_en,
    input  logic [3:0]            bright,
    input  logic                  en,
    output logic                  busy,
    output logic                  frame,
    output logic [7:0]            seg,
    output logic [N_DIGITS-1:0]   an
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [IW-1:0] LAST_IDX   = IW'(N_DIGITS - 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(BLINK_FRAMES - 1);

    logic [PRESCALE-1:0]   pre_cnt;
    logic [IW-1:0]         idx;
    logic [FW-1:0]         frame_cnt;
    logic                  phase;
    logic                  tick;
    logic                  frame_point;

    logic [4*N_DIGITS-1:0] pend_digits;
    logic [N_DIGITS-1:0]   pend_dp;
    logic [N_DIGITS-1:0]   pend_blank;
    logic [N_DIGITS-1:0]   pend_blink;

    logic [4*N_DIGITS-1:0] act_digits;
    logic [N_DIGITS-1:0]   act_dp;
    logic [N_DIGITS-1:0]   act_blank;
    logic [N_DIGITS-1:0]   act_blink;

    logic [N_DIGITS-1:0]   lead_zero;
    logic                  lz_chain;
    logic [3:0]            cur_digit;
    logic [7:0]            glyph;
    logic                  dark;
    logic                  an_on;
    logic [N_DIGITS-1:0]   one_hot;
    logic [7:0]            seg_next;
    logic [N_DIGITS-1:0]   an_next;

    // Active-low glyph table; bit 0 is the decimal point and is left off here.
    function automatic logic [7:0] font(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0: g = 8'h03;
            4'h1: g = 8'h9F;
            4'h2: g = 8'h25;
            4'h3: g = 8'h0D;
            4'h4: g = 8'h99;
            4'h5: g = 8'h49;
            4'h6: g = 8'h41;
            4'h7: g = 8'h1F;
            4'h8: g = 8'h01;
            4'h9: g = 8'h09;
            4'hA: g = 8'h11;
            4'hB: g = 8'hC1;
            4'hC: g = 8'h63;
            4'hD: g = 8'h85;
            4'hE: g = 8'h61;
            default: g = 8'h71;
        endcase
        return g;
    endfunction

    assign tick        = &pre_cnt;
    assign frame_point = tick && (idx == LAST_IDX);

    // Free-running prescaler and digit scan index; the wrap is the frame point.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pre_cnt <= '0;
            idx     <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
            if (tick) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

    // Blink phase flips after every BLINK_FRAMES frame points.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (frame_point) begin
            if (frame_cnt == LAST_FRAME) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Pending buffer and handshake: a load overrides a same-cycle commit for busy.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_blank  <= '0;
            pend_blink  <= '0;
            busy        <= 1'b0;
        end else begin
            if (ld) begin
                pend_digits <= digits;
                pend_dp     <= dp;
                pend_blank  <= blank;
                pend_blink  <= blink;
                busy        <= 1'b1;
            end else if (frame_point && busy) begin
                busy        <= 1'b0;
            end
        end
    end

    // Active buffer takes the old pending contents at the frame point.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            act_digits <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            act_blink  <= '0;
        end else if (frame_point && busy) begin
            act_digits <= pend_digits;
            act_dp     <= pend_dp;
            act_blank  <= pend_blank;
            act_blink  <= pend_blink;
        end
    end

    // Leading-zero mask: digit i is a leading zero when digits i..N-1 are all zero.
    always_comb begin
        lz_chain  = 1'b1;
        lead_zero = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            lz_chain     = lz_chain && (act_digits[4*i +: 4] == 4'h0);
            lead_zero[i] = lz_chain;
        end
    end

    // Segment and anode values for the digit currently under the scan index.
    always_comb begin
        cur_digit = act_digits[{idx, 2'b00} +: 4];
        glyph     = font(cur_digit);
        dark      = act_blank[idx]
                  | (act_blink[idx] & phase)
                  | (lz_en & lead_zero[idx] & (idx != '0));
        seg_next  = dark ? 8'hFF : {glyph[7:1], ~act_dp[idx]};
        an_on     = en && !dark
                  && (pre_cnt[PRESCALE-1 -: 4] <= bright)
                  && (pre_cnt != '0);
        one_hot   = N_DIGITS'(1) << idx;
        an_next   = an_on ? ~one_hot : '1;
    end

    // Registered pin drivers plus the frame pulse.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            seg   <= 8'hFF;
            an    <= '1;
            frame <= 1'b0;
        end else begin
            seg   <= seg_next;
            an    <= an_next;
            frame <= frame_point;
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl
// Directed bench for sseg_scan_ctrl with PRESCALE=5, N_DIGITS=4,
// BLINK_FRAMES=2. A bench cycle counter tracks posedges since reset release;
// pins after posedge c reflect the scan state of cycle c-1, so digit k of
// frame f is visible with its anode lit at c = 128*f + 32*k + 2.
module tb_sseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        ld;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic        lz_en;
    logic [3:0]  bright;
    logic        en;
    logic        busy;
    logic        frame;
    logic [7:0]  seg;
    logic [3:0]  an;

    int checks   = 0;
    int failures = 0;
    int cyc;
    int lit_count;

    sseg_scan_ctrl #(
        .N_DIGITS     (4),
        .PRESCALE     (5),
        .BLINK_FRAMES (2)
    ) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .ld     (ld),
        .digits (digits),
        .dp     (dp),
        .blank  (blank),
        .blink  (blink),
        .lz_en  (lz_en),
        .bright (bright),
        .en     (en),
        .busy   (busy),
        .frame  (frame),
        .seg    (seg),
        .an     (an)
    );

    always #5 clk = ~clk;

    // Posedges since reset release.
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Advance to the negedge following posedge number t.
    task automatic goCycle(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // One-cycle ld strobe; the capture happens at the next posedge.
    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p,
                                 input logic [3:0] bl, input logic [3:0] bk);
        digits = d;
        dp     = p;
        blank  = bl;
        blink  = bk;
        ld     = 1'b1;
        @(negedge clk);
        ld     = 1'b0;
    endtask

    task automatic checkPins(input string tag, input logic [7:0] s, input logic [3:0] a);
        checkOutput({tag, "_seg"}, seg, s);
        checkOutput({tag, "_an"}, an, a);
    endtask

    initial begin
        clr_n  = 1'b0;
        ld     = 1'b0;
        digits = '0;
        dp     = '0;
        blank  = '0;
        blink  = '0;
        lz_en  = 1'b0;
        bright = 4'd15;
        en     = 1'b1;

        repeat (3) @(negedge clk);
        checkPins("reset", 8'hFF, 4'hF);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_frame", frame, 0);
        clr_n = 1'b1;

        goCycle(1);   checkPins("ghost0", 8'h03, 4'hF);
        goCycle(2);   checkPins("scan0", 8'h03, 4'hE);
        goCycle(34);  checkPins("scan1", 8'h03, 4'hD);
        goCycle(66);  checkPins("scan2", 8'h03, 4'hB);
        goCycle(98);  checkPins("scan3", 8'h03, 4'h7);
        goCycle(128); checkOutput("frame_wrap", frame, 1);
        goCycle(129); checkOutput("frame_pulse_end", frame, 0);
        goCycle(130); checkPins("scan0_again", 8'h03, 4'hE);

        $display("[TB] load 12AB mid-frame");
        goCycle(140);
        applyStimulus(16'h12AB, 4'h0, 4'h0, 4'h0);
        checkOutput("ld_busy", busy, 1);
        goCycle(200); checkPins("pins_held", 8'h03, 4'hB);
        goCycle(255); checkOutput("busy_before_wrap", busy, 1);
        checkOutput("frame_before_wrap", frame, 0);
        goCycle(256); checkOutput("commit_frame", frame, 1);
        checkOutput("commit_busy", busy, 0);
        goCycle(257); checkPins("ghost_new", 8'hC1, 4'hF);
        goCycle(258); checkPins("show_B", 8'hC1, 4'hE);
        goCycle(290); checkPins("show_A", 8'h11, 4'hD);
        goCycle(322); checkPins("show_2", 8'h25, 4'hB);
        goCycle(354); checkPins("show_1", 8'h9F, 4'h7);

        $display("[TB] leading-zero suppression");
        goCycle(360);
        lz_en = 1'b1;
        applyStimulus(16'h0070, 4'h0, 4'h0, 4'h0);
        goCycle(386); checkPins("lz_d0", 8'h03, 4'hE);
        goCycle(418); checkPins("lz_d1", 8'h1F, 4'hD);
        goCycle(450); checkPins("lz_d2", 8'hFF, 4'hF);
        goCycle(482); checkPins("lz_d3", 8'hFF, 4'hF);

        $display("[TB] decimal point");
        goCycle(490);
        lz_en = 1'b0;
        applyStimulus(16'h0005, 4'b0010, 4'h0, 4'h0);
        goCycle(514); checkPins("dp_d0", 8'h49, 4'hE);
        goCycle(546); checkPins("dp_d1", 8'h02, 4'hD);

        $display("[TB] brightness");
        goCycle(600);
        bright = 4'd0;
        lit_count = 0;
        for (int c = 641; c <= 672; c++) begin
            goCycle(c);
            if (an[0] == 1'b0) lit_count++;
        end
        checkOutput("bright0_duty", lit_count, 1);
        goCycle(700);
        bright = 4'd15;
        lit_count = 0;
        for (int c = 769; c <= 800; c++) begin
            goCycle(c);
            if (an[0] == 1'b0) lit_count++;
        end
        checkOutput("bright15_duty", lit_count, 31);
        goCycle(850);
        bright = 4'd7;
        lit_count = 0;
        for (int c = 897; c <= 928; c++) begin
            goCycle(c);
            if (an[0] == 1'b0) lit_count++;
        end
        checkOutput("bright7_duty", lit_count, 15);

        goCycle(950);
        en = 1'b0;
        goCycle(962); checkPins("en_off", 8'h03, 4'hF);
        en = 1'b1;
        goCycle(970); checkPins("en_on", 8'h03, 4'hB);
        bright = 4'd15;

        $display("[TB] blink");
        goCycle(1030);
        applyStimulus(16'h0005, 4'h0, 4'h0, 4'b0001);
        goCycle(1154); checkPins("blink_f9", 8'h49, 4'hE);
        goCycle(1282); checkPins("blink_f10", 8'hFF, 4'hF);
        goCycle(1410); checkPins("blink_f11", 8'hFF, 4'hF);
        goCycle(1538); checkPins("blink_f12", 8'h49, 4'hE);
        goCycle(1666); checkPins("blink_f13", 8'h49, 4'hE);

        $display("[TB] last load wins, blank mask");
        goCycle(1700);
        applyStimulus(16'h1111, 4'h0, 4'h0, 4'h0);
        goCycle(1710);
        applyStimulus(16'h2222, 4'h0, 4'b0010, 4'h0);
        goCycle(1794); checkPins("last_wins_d0", 8'h25, 4'hE);
        goCycle(1826); checkPins("blank_d1", 8'hFF, 4'hF);

        $display("[TB] load coinciding with frame point");
        goCycle(1800);
        applyStimulus(16'h4444, 4'h0, 4'h0, 4'h0);
        goCycle(1919);
        applyStimulus(16'h3333, 4'h0, 4'h0, 4'h0);
        checkOutput("same_cycle_busy", busy, 1);
        checkOutput("same_cycle_frame", frame, 1);
        goCycle(1922); checkPins("old_pending", 8'h99, 4'hE);
        goCycle(2048); checkOutput("second_commit_busy", busy, 0);
        goCycle(2050); checkPins("new_pending", 8'h0D, 4'hE);

        $display("[TB] reset mid-scan");
        goCycle(2055);
        applyStimulus(16'h5555, 4'h0, 4'h0, 4'h0);
        checkOutput("pre_reset_busy", busy, 1);
        goCycle(2060);
        #2 clr_n = 1'b0;
        #1;
        checkPins("async_reset", 8'hFF, 4'hF);
        checkOutput("async_reset_busy", busy, 0);
        @(negedge clk);
        clr_n = 1'b1;
        goCycle(2); checkPins("post_reset", 8'h03, 4'hE);
        checkOutput("post_reset_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
